// File: rtl/ctrl_fsm_if.sv
// ctrl_fsm_if
//   Groups the instruction/flag inputs and the control strobes that pass
//   between the multi-cycle control unit and the datapath.
//   master : control unit (consumes instr/zero, drives every strobe)
//   slave  : datapath side (drives instr/zero, consumes every strobe)
//   Signals:
//     instr      16      IR contents
//     zero       1       registered ALU zero flag
//     inc_PC     1       PC+1 at this edge
//     pc_src     1       PC <= next_addr at this edge
//     halt       1       PC holds
//     next_addr  ADDR_W  branch/jump target
//     ir_load    1       IR <= imem[pc]
//     mem_read   1       data memory read strobe
//     mem_write  1       data memory write strobe
//     reg_write  1       register file write
//     wb_sel     2       00 ALU, 01 mem data, 10 immediate
//     alu_op     4       0 ADD, 1 SUB, 2 AND, 3 OR
//     retire     1       final-state pulse of an instruction
//     illegal    1       sticky undefined-opcode flag
interface ctrl_fsm_if #(
    parameter int ADDR_W = 8
);
    logic [15:0]       instr;
    logic              zero;
    logic              inc_PC;
    logic              pc_src;
    logic              halt;
    logic [ADDR_W-1:0] next_addr;
    logic              ir_load;
    logic              mem_read;
    logic              mem_write;
    logic              reg_write;
    logic [1:0]        wb_sel;
    logic [3:0]        alu_op;
    logic              retire;
    logic              illegal;

    modport master (
        input  instr, zero,
        output inc_PC, pc_src, halt, next_addr, ir_load, mem_read, mem_write,
               reg_write, wb_sel, alu_op, retire, illegal
    );

    modport slave (
        output instr, zero,
        input  inc_PC, pc_src, halt, next_addr, ir_load, mem_read, mem_write,
               reg_write, wb_sel, alu_op, retire, illegal
    );
endinterface

// File: rtl/ctrl_fsm.sv
// ctrl_fsm
//   Multi-cycle control unit. Steps each 16-bit instruction through
//   FETCH / DECODE / EXEC / MEM / WB and drives the PC, IR, data memory,
//   register file and ALU control strobes. Undefined opcodes set a sticky
//   illegal flag and either halt or behave as NOP (ILLEGAL_HALTS).
//   Ports:
//     clk    in  single clock, all state changes on posedge
//     reset  in  synchronous, active-high; forces every output to 0
//     bus    ctrl_fsm_if.master  instruction/flag inputs and control strobes
module ctrl_fsm #(
    parameter int ADDR_W        = 8,
    parameter bit ILLEGAL_HALTS = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    ctrl_fsm_if.master  bus
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALTED = 3'd5
    } state_t;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_AND = 4'h3;
    localparam logic [3:0] OP_OR  = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_LD  = 4'h6;
    localparam logic [3:0] OP_ST  = 4'h7;
    localparam logic [3:0] OP_JMP = 4'h8;
    localparam logic [3:0] OP_BEQ = 4'h9;
    localparam logic [3:0] OP_BNE = 4'hA;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;

    state_t     state_reg, state_next;
    logic       illegal_reg;
    logic       set_illegal;
    logic [3:0] opcode;

    // Raw decoded strobes; gated with reset below so nothing escapes
    // during a reset cycle.
    logic       inc_pc_c, pc_src_c, halt_c, ir_load_c;
    logic       mem_read_c, mem_write_c, reg_write_c, retire_c;
    logic [1:0] wb_sel_c;
    logic [3:0] alu_op_c;

    // instr is stable from DECODE until the next FETCH, so the opcode is
    // decoded straight from it in every state rather than latched.
    assign opcode = bus.instr[15:12];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= S_FETCH;
            illegal_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (set_illegal) begin
                illegal_reg <= 1'b1;
            end
        end
    end

    always_comb begin
        state_next  = state_reg;
        set_illegal = 1'b0;
        inc_pc_c    = 1'b0;
        pc_src_c    = 1'b0;
        halt_c      = 1'b0;
        ir_load_c   = 1'b0;
        mem_read_c  = 1'b0;
        mem_write_c = 1'b0;
        reg_write_c = 1'b0;
        retire_c    = 1'b0;
        wb_sel_c    = 2'b00;
        alu_op_c    = ALU_ADD;

        case (state_reg)
            S_FETCH: begin
                ir_load_c  = 1'b1;
                inc_pc_c   = 1'b1;
                state_next = S_DECODE;
            end

            S_DECODE: begin
                case (opcode)
                    OP_NOP: begin
                        retire_c   = 1'b1;
                        state_next = S_FETCH;
                    end
                    OP_LDI: state_next = S_WB;
                    OP_ADD, OP_SUB, OP_AND, OP_OR,
                    OP_LD, OP_ST, OP_JMP, OP_BEQ, OP_BNE: state_next = S_EXEC;
                    OP_HLT: state_next = S_HALTED;
                    default: begin
                        set_illegal = 1'b1;
                        if (ILLEGAL_HALTS) begin
                            state_next = S_HALTED;
                        end else begin
                            retire_c   = 1'b1;
                            state_next = S_FETCH;
                        end
                    end
                endcase
            end

            S_EXEC: begin
                state_next = S_FETCH;
                case (opcode)
                    OP_ADD: begin alu_op_c = ALU_ADD; state_next = S_WB; end
                    OP_SUB: begin alu_op_c = ALU_SUB; state_next = S_WB; end
                    OP_AND: begin alu_op_c = ALU_AND; state_next = S_WB; end
                    OP_OR:  begin alu_op_c = ALU_OR;  state_next = S_WB; end
                    // Memory address is base + offset, formed by an ADD.
                    OP_LD, OP_ST: begin
                        alu_op_c   = ALU_ADD;
                        state_next = S_MEM;
                    end
                    OP_JMP: begin pc_src_c = 1'b1;      retire_c = 1'b1; end
                    OP_BEQ: begin pc_src_c = bus.zero;  retire_c = 1'b1; end
                    OP_BNE: begin pc_src_c = ~bus.zero; retire_c = 1'b1; end
                    default: state_next = S_FETCH;
                endcase
            end

            S_MEM: begin
                if (opcode == OP_LD) begin
                    mem_read_c = 1'b1;
                    state_next = S_WB;
                end else if (opcode == OP_ST) begin
                    mem_write_c = 1'b1;
                    retire_c    = 1'b1;
                    state_next  = S_FETCH;
                end else begin
                    state_next = S_FETCH;
                end
            end

            S_WB: begin
                reg_write_c = 1'b1;
                retire_c    = 1'b1;
                state_next  = S_FETCH;
                if (opcode == OP_LD) begin
                    wb_sel_c = 2'b01;
                end else if (opcode == OP_LDI) begin
                    wb_sel_c = 2'b10;
                end
            end

            S_HALTED: begin
                halt_c = 1'b1;
            end

            // Unused state encodings fall back into the fetch cycle.
            default: state_next = S_FETCH;
        endcase
    end

    assign bus.inc_PC    = inc_pc_c    & ~reset;
    assign bus.pc_src    = pc_src_c    & ~reset;
    assign bus.halt      = halt_c      & ~reset;
    assign bus.ir_load   = ir_load_c   & ~reset;
    assign bus.mem_read  = mem_read_c  & ~reset;
    assign bus.mem_write = mem_write_c & ~reset;
    assign bus.reg_write = reg_write_c & ~reset;
    assign bus.retire    = retire_c    & ~reset;
    assign bus.illegal   = illegal_reg & ~reset;
    assign bus.wb_sel    = reset ? 2'b00 : wb_sel_c;
    assign bus.alu_op    = reset ? 4'd0  : alu_op_c;
    assign bus.next_addr = reset ? '0    : bus.instr[ADDR_W-1:0];

endmodule

// File: tb/tb_ctrl_fsm.sv
module tb_ctrl_fsm;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    ctrl_fsm_if #(.ADDR_W(8)) bus ();

    ctrl_fsm #(
        .ADDR_W        (8),
        .ILLEGAL_HALTS (1'b1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    int n_checks = 0;
    int n_errors = 0;
    bit exp_illegal = 1'b0;

    // Observation vector layout:
    // 14 inc_PC, 13 pc_src, 12 halt, 11 ir_load, 10 mem_read, 9 mem_write,
    // 8 reg_write, 7:6 wb_sel, 5:2 alu_op, 1 retire, 0 illegal
    localparam logic [14:0] V_INC = 15'h4000;
    localparam logic [14:0] V_PCS = 15'h2000;
    localparam logic [14:0] V_HLT = 15'h1000;
    localparam logic [14:0] V_IRL = 15'h0800;
    localparam logic [14:0] V_MRD = 15'h0400;
    localparam logic [14:0] V_MWR = 15'h0200;
    localparam logic [14:0] V_RW  = 15'h0100;
    localparam logic [14:0] V_RET = 15'h0002;

    function automatic logic [14:0] v_wb(input int sel);
        return 15'(sel) << 6;
    endfunction

    function automatic logic [14:0] v_alu(input int op);
        return 15'(op) << 2;
    endfunction

    function automatic logic [14:0] obs();
        return {bus.inc_PC, bus.pc_src, bus.halt, bus.ir_load, bus.mem_read,
                bus.mem_write, bus.reg_write, bus.wb_sel, bus.alu_op,
                bus.retire, bus.illegal};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock cycle: compare at the falling edge, then step past the
    // next rising edge so the caller can change inputs.
    task automatic sample(input string tag, input logic [14:0] exp, input logic [7:0] exp_na);
        @(negedge clk);
        check({tag, ".out"}, 32'(obs()), 32'(exp));
        check({tag, ".next_addr"}, 32'(bus.next_addr), 32'(exp_na));
        check({tag, ".inc_pcsrc_excl"}, 32'(bus.inc_PC & bus.pc_src), 32'd0);
        check({tag, ".rd_wr_excl"}, 32'(bus.mem_read & bus.mem_write), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b1;
        for (int k = 0; k < cycles; k++) begin
            sample($sformatf("reset%0d", k), 15'h0, 8'h00);
        end
        reset = 1'b0;
        exp_illegal = 1'b0;
    endtask

    // Reference: the per-cycle output sequence each instruction class
    // produces, indexed from its FETCH cycle. abort >= 0 asserts reset in
    // that cycle of the sequence instead of letting it complete.
    task automatic run_instr(input logic [15:0] ins, input bit z, input int abort,
                             input int halt_cycles);
        logic [3:0]  op;
        logic [14:0] seq[$];
        logic [14:0] e;
        bit          halts;
        bit          ill;
        op    = ins[15:12];
        halts = 1'b0;
        ill   = (op >= 4'hB) && (op <= 4'hE);
        bus.instr = ins;
        bus.zero  = z;
        seq.push_back(V_INC | V_IRL);
        case (op)
            4'h0: seq.push_back(V_RET);
            4'h1, 4'h2, 4'h3, 4'h4: begin
                seq.push_back(15'h0);
                seq.push_back(v_alu(int'(op) - 1));
                seq.push_back(V_RW | v_wb(0) | V_RET);
            end
            4'h5: begin
                seq.push_back(15'h0);
                seq.push_back(V_RW | v_wb(2) | V_RET);
            end
            4'h6: begin
                seq.push_back(15'h0);
                seq.push_back(v_alu(0));
                seq.push_back(V_MRD);
                seq.push_back(V_RW | v_wb(1) | V_RET);
            end
            4'h7: begin
                seq.push_back(15'h0);
                seq.push_back(v_alu(0));
                seq.push_back(V_MWR | V_RET);
            end
            4'h8: begin seq.push_back(15'h0); seq.push_back(V_PCS | V_RET); end
            4'h9: begin seq.push_back(15'h0); seq.push_back((z ? V_PCS : 15'h0) | V_RET); end
            4'hA: begin seq.push_back(15'h0); seq.push_back((!z ? V_PCS : 15'h0) | V_RET); end
            default: begin
                seq.push_back(15'h0);
                halts = 1'b1;
            end
        endcase

        for (int k = 0; k < seq.size(); k++) begin
            if (k == abort) begin
                do_reset(1);
                return;
            end
            // illegal becomes visible one cycle after DECODE
            e = seq[k] | 15'((k >= 2) ? (exp_illegal | ill) : exp_illegal);
            sample($sformatf("op%h.c%0d", op, k), e, ins[7:0]);
        end
        exp_illegal = exp_illegal | ill;

        if (halts) begin
            for (int h = 0; h < halt_cycles; h++) begin
                bus.instr = 16'($urandom);
                bus.zero  = 1'($urandom);
                sample($sformatf("halted%h.c%0d", op, h), V_HLT | 15'(exp_illegal),
                       bus.instr[7:0]);
            end
            do_reset(2);
        end
        $display("instr=0x%04h zero=%0d abort=%0d checks=%0d errors=%0d",
                 ins, z, abort, n_checks, n_errors);
    endtask

    initial begin
        reset     = 1'b1;
        bus.instr = 16'h0000;
        bus.zero  = 1'b0;
        do_reset(2);

        // Directed cases
        run_instr(16'h1ABC, 1'b0, -1, 0);     // ADD
        run_instr(16'h900A, 1'b1, -1, 0);     // BEQ taken
        run_instr(16'h900A, 1'b0, -1, 0);     // BEQ not taken
        run_instr(16'hA0FF, 1'b0, -1, 0);     // BNE taken, target 0xFF
        run_instr(16'h8042, 1'b0, -1, 0);     // JMP
        run_instr(16'h6123, 1'b0, -1, 0);     // LD
        run_instr(16'h7321, 1'b1, -1, 0);     // ST
        run_instr(16'h5077, 1'b0, -1, 0);     // LDI
        run_instr(16'h0000, 1'b0, -1, 0);     // NOP
        run_instr(16'hF000, 1'b0, -1, 12);    // HLT held, then reset
        run_instr(16'hC000, 1'b0, -1, 12);    // illegal -> sticky + halted
        run_instr(16'h2111, 1'b0, -1, 0);     // after reset: illegal cleared
        run_instr(16'h1234, 1'b0, 2, 0);      // reset during EXEC of ADD
        run_instr(16'h3456, 1'b1, -1, 0);     // AND, FETCH follows release

        // Randomized instruction stream with occasional mid-instruction resets
        for (int i = 0; i < 300; i++) begin
            logic [15:0] ins;
            int          ab;
            ins = 16'($urandom);
            ab  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 4)) : -1;
            run_instr(ins, 1'($urandom), ab, int'($urandom_range(1, 5)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
